// File: rtl/palette_ram_ctrl_if.sv
// CPU-side palette RAM access bus: 4-phase REQ/ACK handshake with
// write data in and read data out. The CPU drives the master side,
// palette_ram_ctrl sits on the slave side.
interface palette_ram_ctrl_if #(
  parameter int IDX_W  = 12,
  parameter int DATA_W = 16
);
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [IDX_W-1:0]  CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_ACK;
  logic [DATA_W-1:0] CPU_RDATA;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  CPU_ACK, CPU_RDATA
  );

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output CPU_ACK, CPU_RDATA
  );
endinterface

// File: rtl/palette_ram_ctrl.sv
// Palette RAM controller in front of the video output latch stage.
// Turns the LSPC colour index into a palette word PC with an aligned
// blanking flag (fixed 2-clock latency) and shares the single-port
// palette RAM with the 68k. The CPU gets the port during blanking, or
// steals one cycle after waiting CPU_WAIT_MAX cycles in active display.
//
// Optional build macro PAL_STEAL_STATS_EN: adds STEAL_CNT, a saturating
// count of accesses forced in via cycle-steal during active display.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no CPU request pending, video owns the RAM
// ST_WAIT    | request pending during active display, wait counter runs
// ST_ACCESS  | CPU owns the RAM for this one cycle (write or read)
// ST_ACK     | CPU_ACK high, waiting for CPU_REQ to fall
module palette_ram_ctrl #(
  parameter int IDX_W        = 12,
  parameter int DATA_W       = 16,
  parameter int CPU_WAIT_MAX = 16
) (
  input  logic              CLK_6MB,
  input  logic              nRESET,
  input  logic [IDX_W-1:0]  PIXEL_IDX,
  input  logic              nBNK_IN,
  input  logic              PALBNK,
  palette_ram_ctrl_if.slave cpu,
  output logic [DATA_W-1:0] PC,
  output logic              nBNKB
`ifdef PAL_STEAL_STATS_EN
  ,
  output logic [15:0]       STEAL_CNT
`endif
);

  localparam int ADDR_W = IDX_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = (CPU_WAIT_MAX > 1) ? $clog2(CPU_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPU_WAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;

  logic [ADDR_W-1:0] s1_addr;
  logic              s1_nbnk;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              cpu_own;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  // FSM state and wait counter registers
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: grant in blanking at once, otherwise wait and steal
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        wait_cnt_nxt = '0;
        if (cpu.CPU_REQ) begin
          state_nxt = nBNK_IN ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (!cpu.CPU_REQ) begin
          state_nxt = ST_IDLE;
        end else if (!nBNK_IN || (wait_cnt == CNT_LAST)) begin
          state_nxt = ST_ACCESS;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (!cpu.CPU_REQ) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Single RAM port: the CPU owns it only in ACCESS; read-first on writes
  assign cpu_own  = (state == ST_ACCESS);
  assign ram_addr = cpu_own ? {PALBNK, cpu.CPU_ADDR} : s1_addr;
  assign ram_we   = cpu_own && cpu.CPU_WE;
  assign ram_q    = mem[ram_addr];

  // Palette storage, deliberately not reset
  always_ff @(posedge CLK_6MB) begin
    if (ram_we) begin
      mem[ram_addr] <= cpu.CPU_WDATA;
    end
  end

  // Video pipeline: S1 captures address and blank, S2 captures RAM data
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      s1_addr <= '0;
      s1_nbnk <= 1'b0;
      PC      <= '0;
      nBNKB   <= 1'b0;
    end else begin
      s1_addr <= {PALBNK, PIXEL_IDX};
      s1_nbnk <= nBNK_IN;
      nBNKB   <= s1_nbnk;
      if (!cpu_own) begin
        PC <= ram_q;
      end
    end
  end

  // CPU response: ACK follows the ACK state, read data captured in ACCESS
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      cpu.CPU_ACK   <= 1'b0;
      cpu.CPU_RDATA <= '0;
    end else begin
      cpu.CPU_ACK <= (state_nxt == ST_ACK);
      if (cpu_own && !cpu.CPU_WE) begin
        cpu.CPU_RDATA <= ram_q;
      end
    end
  end

`ifdef PAL_STEAL_STATS_EN
  logic steal_entry;

  // A steal is an entry into ACCESS while the display is still active
  assign steal_entry = (state == ST_WAIT) && (state_nxt == ST_ACCESS) && nBNK_IN;

  // Saturating steal counter, cleared only by reset
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      STEAL_CNT <= '0;
    end else if (steal_entry && (STEAL_CNT != 16'hFFFF)) begin
      STEAL_CNT <= STEAL_CNT + 16'd1;
    end
  end
`endif

endmodule
